// File: rtl/task_tick_scheduler.sv
// Programmable tick prescaler plus a one-at-a-time task round scheduler.
// Each tick starts a round over the masked tasks, lowest index first.
module task_tick_scheduler #(
    parameter int DIV_WIDTH   = 16,
    parameter int DIV_DEFAULT = 250,
    parameter int NUM_TASKS   = 3,
    parameter int TIMEOUT     = 1000
) (
    input  logic                 i_main_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic                 i_div_load,
    input  logic [DIV_WIDTH-1:0] i_div_value,
    input  logic [NUM_TASKS-1:0] i_task_mask,
    input  logic [NUM_TASKS-1:0] i_task_done,
    input  logic                 i_err_clr,
    output logic                 o_tick,
    output logic [NUM_TASKS-1:0] o_task_start,
    output logic                 o_busy,
    output logic [NUM_TASKS-1:0] o_timeout_err,
    output logic                 o_overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [NUM_TASKS-1:0] TASK_ONE = NUM_TASKS'(1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT
    } state_t;

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    state_t               r_state;
    logic [NUM_TASKS-1:0] r_pending;
    logic [NUM_TASKS-1:0] r_cur;
    logic [TW-1:0]        r_timer;
    logic [NUM_TASKS-1:0] r_start;
    logic                 r_busy;
    logic [NUM_TASKS-1:0] r_terr;
    logic                 r_ovr;

    logic [DIV_WIDTH-1:0] w_div_last;
    logic [DIV_WIDTH-1:0] w_div_new;
    logic                 w_wrap;
    logic                 w_tick;
    logic [NUM_TASKS-1:0] w_low;
    logic                 w_done_cur;
    logic                 w_timer_end;
    logic                 w_to_hit;
    logic                 w_ovr_set;

    assign w_div_last  = r_div - DIV_ONE;
    assign w_div_new   = (i_div_value == '0) ? DIV_ONE : i_div_value;
    assign w_wrap      = (r_cnt == w_div_last);
    // A load cycle restarts the period, so the old period never ticks.
    assign w_tick      = i_rst_n & i_enable & ~i_div_load & w_wrap;
    assign w_low       = r_pending & (~r_pending + TASK_ONE);
    assign w_done_cur  = |(i_task_done & r_cur);
    assign w_timer_end = (r_timer == TIMER_LAST);
    assign w_to_hit    = (r_state == S_WAIT) & ~w_done_cur & w_timer_end;
    assign w_ovr_set   = w_tick & (r_state != S_IDLE);

    always_ff @(posedge i_main_clk) begin
        if (!i_rst_n) begin
            r_div <= DIV_WIDTH'(DIV_DEFAULT);
            r_cnt <= '0;
        end else if (i_div_load) begin
            r_div <= w_div_new;
            r_cnt <= '0;
        end else if (!i_enable || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_ONE;
        end
    end

    // Setting an error in the same cycle as a clear keeps the error.
    always_ff @(posedge i_main_clk) begin
        if (!i_rst_n) begin
            r_terr <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_terr <= (i_err_clr ? '0 : r_terr) | (w_to_hit ? r_cur : '0);
            r_ovr  <= (r_ovr & ~i_err_clr) | w_ovr_set;
        end
    end

    always_ff @(posedge i_main_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_cur     <= '0;
            r_timer   <= '0;
            r_start   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_start <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_pending <= i_task_mask;
                        r_state   <= S_SELECT;
                        r_busy    <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (r_pending == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cur     <= w_low;
                        r_pending <= r_pending & ~w_low;
                        r_start   <= w_low;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_cur || w_timer_end) begin
                        r_state <= S_SELECT;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tick        = w_tick;
    assign o_task_start  = r_start;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_terr;
    assign o_overrun     = r_ovr;

endmodule

// File: tb/tb_task_tick_scheduler.sv
// Directed bench for task_tick_scheduler: prescaler table plus
// hand-timed round, timeout, overrun and mid-round reset sequences.
module tb_task_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ld;
    logic [15:0] dv;
    logic [2:0]  mask;
    logic [2:0]  done;
    logic        clr;
    logic        tick;
    logic [2:0]  start;
    logic        busy;
    logic [2:0]  terr;
    logic        ovr;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task_tick_scheduler #(
        .DIV_WIDTH(16),
        .DIV_DEFAULT(250),
        .NUM_TASKS(3),
        .TIMEOUT(1000)
    ) dut (
        .i_main_clk(clk),
        .i_rst_n(rst_n),
        .i_enable(en),
        .i_div_load(ld),
        .i_div_value(dv),
        .i_task_mask(mask),
        .i_task_done(done),
        .i_err_clr(clr),
        .o_tick(tick),
        .o_task_start(start),
        .o_busy(busy),
        .o_timeout_err(terr),
        .o_overrun(ovr)
    );

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] v;
        logic        tk;
        logic        bz;
        logic        ov;
    } vec_t;

    vec_t tbl [0:23];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h",
                     nm, $time, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1}
        };

        rst_n = 1'b0;
        en    = 1'b0;
        ld    = 1'b0;
        dv    = '0;
        mask  = '0;
        done  = '0;
        clr   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tick", tick, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", terr, 0);
        chk("rst_ovr", ovr, 0);

        rst_n = 1'b1;
        en    = 1'b1;
        for (int c = 0; c <= 501; c++) begin
            #1;
            chk("dflt_tick", tick, (c == 249 || c == 499));
            chk("dflt_busy", busy, (c == 250 || c == 500));
            nxt();
        end

        for (int i = 0; i < 24; i++) begin
            en = tbl[i].en;
            ld = tbl[i].ld;
            dv = tbl[i].v;
            #1;
            chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tk);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
            chk($sformatf("tbl%0d_ovr", i), ovr, tbl[i].ov);
            nxt();
        end
        ld = 1'b0;
        en = 1'b0;

        clr = 1'b1;
        #1;
        chk("clr_same_cycle", ovr, 1);
        nxt();
        clr = 1'b0;
        #1;
        chk("clr_next_cycle", ovr, 0);
        nxt();

        for (int k = 0; k <= 20; k++) begin
            en = (k == 0);
            mask = (k >= 3) ? 3'b010 : 3'b101;
            done = (k == 2)  ? 3'b001 :
                   (k == 4)  ? 3'b010 :
                   (k == 7)  ? 3'b001 :
                   (k == 14) ? 3'b100 : 3'b000;
            #1;
            chk($sformatf("rnd%0d_tick", k), tick, (k == 0));
            chk($sformatf("rnd%0d_start", k), start,
                (k == 2) ? 3'b001 : (k == 9) ? 3'b100 : 3'b000);
            chk($sformatf("rnd%0d_busy", k), busy, (k >= 1 && k <= 15));
            nxt();
        end
        en = 1'b0;
        done = '0;
        mask = '0;
        #1;
        chk("rnd_terr", terr, 0);
        chk("rnd_ovr", ovr, 0);
        nxt();

        mask = 3'b001;
        for (int k = 0; k <= 1006; k++) begin
            en = (k == 0);
            #1;
            chk("to_start", start, (k == 2) ? 3'b001 : 3'b000);
            chk("to_busy", busy, (k >= 1 && k <= 1003));
            chk("to_terr", terr, (k >= 1003) ? 3'b001 : 3'b000);
            nxt();
        end
        en = 1'b0;
        clr = 1'b1;
        #1;
        chk("to_clr_same", terr, 3'b001);
        nxt();
        clr = 1'b0;
        #1;
        chk("to_clr_next", terr, 3'b000);
        nxt();

        en = 1'b1;
        ld = 1'b1;
        dv = 16'd8;
        #1;
        chk("ov_load_tick", tick, 0);
        nxt();
        ld = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            #1;
            chk("ov_pre_tick", tick, 0);
            nxt();
        end
        for (int k = 0; k <= 47; k++) begin
            done = (k == 22 || k == 28 || k == 42) ? 3'b001 : 3'b000;
            clr  = (k == 30 || k == 40);
            #1;
            chk($sformatf("ov%0d_tick", k), tick, (k % 8 == 0));
            chk($sformatf("ov%0d_start", k), start,
                (k == 2 || k == 26 || k == 34) ? 3'b001 : 3'b000);
            chk($sformatf("ov%0d_busy", k), busy,
                (k >= 1 && k <= 23) || (k >= 25 && k <= 29) ||
                (k >= 33 && k <= 43));
            chk($sformatf("ov%0d_ovr", k), ovr,
                (k >= 9 && k <= 30) || (k >= 41));
            nxt();
        end
        en = 1'b0;
        done = '0;
        clr = 1'b0;
        #1;
        chk("ov_terr", terr, 0);
        nxt();

        ld = 1'b1;
        dv = 16'd1;
        nxt();
        ld = 1'b0;
        mask = 3'b001;
        for (int k = 0; k <= 5; k++) begin
            en = (k == 0);
            done = (k == 4) ? 3'b010 : 3'b000;
            #1;
            chk($sformatf("mr%0d_start", k), start,
                (k == 2) ? 3'b001 : 3'b000);
            chk($sformatf("mr%0d_busy", k), busy, (k >= 1));
            if (k == 5) rst_n = 1'b0;
            nxt();
        end
        rst_n = 1'b1;
        done = '0;
        en = 1'b1;
        for (int c = 0; c <= 250; c++) begin
            #1;
            chk("prst_start", start, 0);
            chk("prst_tick", tick, (c == 249));
            chk("prst_busy", busy, (c == 250));
            nxt();
        end
        en = 1'b0;
        mask = '0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
